// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-requester front end for a shared combinational 4-bit ALU
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   reqN_valid/ready/a/b/sel          requester N operation handshake and operands (N = 0, 1)
//   alu_a, alu_b, alu_sel             registered operands driven to the external ALU
//   alu_out, alu_carry                combinational ALU result returned to the arbiter
//   rsp_valid/ready/id/result/carry/err  tagged response handshake
//   op_count                          completed responses, wrapping
module alu_arbiter #(
    parameter int DIV_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [3:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [3:0]       req1_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [3:0] SEL_DIV = 4'b0011;
    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       a_q, a_d, b_q, b_d, sel_q, sel_d, cnt_q, cnt_d;
    logic             id_q, id_d, rv_q, rv_d, carry_q, carry_d, err_q, err_d;
    logic [7:0]       res_q, res_d;
    logic [CNT_W-1:0] ops_q, ops_d;
    logic             g0, g1, div_zero;
    logic [3:0]       in_sel;
    // On contention the requester that was not served last wins.
    assign g0 = (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
    assign g1 = (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);
    assign req0_ready = g0 && !rst;
    assign req1_ready = g1 && !rst;
    assign in_sel   = g0 ? req0_sel : req1_sel;
    assign div_zero = (sel_q == SEL_DIV) && (b_q == 4'd0);
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        rv_d    = rv_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        ops_d   = ops_q;
        case (state_q)
            IDLE: if (g0 || g1) begin
                a_d     = g0 ? req0_a : req1_a;
                b_d     = g0 ? req0_b : req1_b;
                sel_d   = in_sel;
                id_d    = g1;
                cnt_d   = (in_sel == SEL_DIV) ? 4'(DIV_CYCLES) : 4'd1;
                state_d = EXEC;
            end
            EXEC: if (cnt_q > 4'd1) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                // Divide by zero reports an error with a clean zero result.
                res_d   = div_zero ? 8'h00 : alu_out;
                carry_d = div_zero ? 1'b0 : alu_carry;
                err_d   = div_zero;
                rv_d    = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                rv_d    = 1'b0;
                last_d  = id_q;
                ops_d   = ops_q + CNT_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            rv_q    <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            ops_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            ops_q   <= ops_d;
        end
    end
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = rv_q;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_err    = err_q;
    assign op_count   = ops_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, division, backpressure and reset
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_a = '0, req0_b = '0, req0_sel = '0;
    logic [3:0]  req1_a = '0, req1_b = '0, req1_sel = '0;
    logic [3:0]  alu_a, alu_b, alu_sel;
    logic [7:0]  alu_out;
    logic        alu_carry;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_carry, rsp_err;
    logic [7:0]  rsp_result;
    logic [15:0] op_count;
    logic [4:0]  sum;
    int pass = 0, total = 0;

    alu_arbiter #(.DIV_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU: 0000 add (carry = bit 4), 0011 divide, otherwise concatenation.
    // Divide by zero returns garbage so the arbiter's forcing is observable.
    assign sum = {1'b0, alu_a} + {1'b0, alu_b};
    always_comb begin
        alu_out   = {alu_a, alu_b};
        alu_carry = 1'b0;
        if (alu_sel == 4'b0000) begin
            alu_out   = {3'b000, sum};
            alu_carry = sum[4];
        end else if (alu_sel == 4'b0011) begin
            alu_out   = (alu_b == 4'd0) ? 8'hFF : {4'b0000, alu_a / alu_b};
            alu_carry = (alu_b == 4'd0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Presents one op, waits for accept, then keeps both valids high until the response
    // appears so any ready outside IDLE is caught. Returns cycles from accept to rsp_valid.
    task automatic do_op(input logic r, input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                         output int lat, output bit stable, output bit busy);
        int n;
        stable = 1'b1;
        busy   = 1'b0;
        lat    = 99;
        if (r) begin
            req1_a = a; req1_b = b; req1_sel = s; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_sel = s; req0_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(r ? req1_ready : req0_ready) && n < 20) begin
            tick;
            n++;
        end
        if (n < 20) begin
            tick;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            lat = 1;
            while (!rsp_valid && lat < 40) begin
                if (alu_a !== a || alu_b !== b || alu_sel !== s) stable = 1'b0;
                if (req0_ready || req1_ready) busy = 1'b1;
                tick;
                lat++;
            end
            if (req0_ready || req1_ready) busy = 1'b1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick;
        total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); else pass++;
        total++; if ({alu_a, alu_b, alu_sel} !== 12'h000) $display("FAIL reset_alu got %h exp 000", {alu_a, alu_b, alu_sel}); else pass++;
        total++; if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err} !== 12'h000) $display("FAIL reset_rsp got %h exp 000", {rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err}); else pass++;
        total++; if (op_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", op_count); else pass++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_req0_add;
        int lat; bit st, bz;
        do_op(1'b0, 4'd3, 4'd5, 4'b0000, lat, st, bz);
        total++; if (lat !== 2) $display("FAIL r0_latency got %0d exp 2", lat); else pass++;
        total++; if ({rsp_id, rsp_result, rsp_carry, rsp_err} !== {1'b0, 8'h08, 1'b0, 1'b0}) $display("FAIL r0_rsp got id=%b res=%h c=%b e=%b exp id=0 res=08 c=0 e=0", rsp_id, rsp_result, rsp_carry, rsp_err); else pass++;
        total++; if (bz !== 1'b0) $display("FAIL r0_busy_ready got %b exp 0", bz); else pass++;
        tick;
        total++; if (op_count !== 16'd1) $display("FAIL r0_count got %0d exp 1", op_count); else pass++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL r0_valid_drop got %b exp 0", rsp_valid); else pass++;
    endtask

    task automatic test_req1_add;
        int lat; bit st, bz;
        do_op(1'b1, 4'd9, 4'd8, 4'b0000, lat, st, bz);
        total++; if (lat !== 2) $display("FAIL r1_latency got %0d exp 2", lat); else pass++;
        total++; if ({rsp_id, rsp_result, rsp_carry, rsp_err} !== {1'b1, 8'h11, 1'b1, 1'b0}) $display("FAIL r1_rsp got id=%b res=%h c=%b e=%b exp id=1 res=11 c=1 e=0", rsp_id, rsp_result, rsp_carry, rsp_err); else pass++;
        tick;
        total++; if (op_count !== 16'd2) $display("FAIL r1_count got %0d exp 2", op_count); else pass++;
    endtask

    task automatic test_div;
        int lat; bit st, bz;
        do_op(1'b0, 4'd13, 4'd4, 4'b0011, lat, st, bz);
        total++; if (lat !== 5) $display("FAIL div_latency got %0d exp 5", lat); else pass++;
        total++; if (st !== 1'b1) $display("FAIL div_alu_stable got %b exp 1", st); else pass++;
        total++; if (bz !== 1'b0) $display("FAIL div_busy_ready got %b exp 0", bz); else pass++;
        total++; if ({rsp_id, rsp_result, rsp_carry, rsp_err} !== {1'b0, 8'h03, 1'b0, 1'b0}) $display("FAIL div_rsp got id=%b res=%h c=%b e=%b exp id=0 res=03 c=0 e=0", rsp_id, rsp_result, rsp_carry, rsp_err); else pass++;
        tick;
    endtask

    task automatic test_div_zero;
        int lat; bit st, bz;
        do_op(1'b1, 4'd7, 4'd0, 4'b0011, lat, st, bz);
        total++; if (lat !== 5) $display("FAIL div0_latency got %0d exp 5", lat); else pass++;
        total++; if ({rsp_id, rsp_result, rsp_carry, rsp_err} !== {1'b1, 8'h00, 1'b0, 1'b1}) $display("FAIL div0_rsp got id=%b res=%h c=%b e=%b exp id=1 res=00 c=0 e=1", rsp_id, rsp_result, rsp_carry, rsp_err); else pass++;
        tick;
        total++; if (op_count !== 16'd4) $display("FAIL div0_count got %0d exp 4", op_count); else pass++;
    endtask

    task automatic test_back_to_back;
        int acc_cyc[8];
        int acc_id[8];
        int n = 0, nrsp = 0, bad_rsp = 0, bad_rdy = 0;
        rst = 1'b1;
        req0_a = 4'd1;  req0_b = 4'd2;  req0_sel = 4'b0000;
        req1_a = 4'd15; req1_b = 4'd15; req1_sel = 4'b0000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (req0_ready && req1_ready) bad_rdy++;
            if ((req0_ready || req1_ready) && rsp_valid) bad_rdy++;
            if ((req0_ready || req1_ready) && n < 8) begin
                acc_cyc[n] = i;
                acc_id[n]  = req1_ready ? 1 : 0;
                n++;
            end
            if (rsp_valid) begin
                if (rsp_id !== nrsp[0]) bad_rsp++;
                if (rsp_result !== (nrsp[0] ? 8'h1E : 8'h03)) bad_rsp++;
                if (rsp_carry !== nrsp[0]) bad_rsp++;
                nrsp++;
            end
            tick;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        total++; if (n !== 4) $display("FAIL b2b_accepts got %0d exp 4", n); else pass++;
        for (int k = 0; k < 4; k++) begin
            total++; if (acc_cyc[k] !== 3 * k || acc_id[k] !== k % 2) $display("FAIL b2b_accept%0d got cyc=%0d id=%0d exp cyc=%0d id=%0d", k, acc_cyc[k], acc_id[k], 3 * k, k % 2); else pass++;
        end
        total++; if (bad_rdy !== 0) $display("FAIL b2b_ready_outside_idle got %0d exp 0", bad_rdy); else pass++;
        total++; if (nrsp !== 4 || bad_rsp !== 0) $display("FAIL b2b_responses got n=%0d bad=%0d exp n=4 bad=0", nrsp, bad_rsp); else pass++;
        total++; if (op_count !== 16'd4) $display("FAIL b2b_count got %0d exp 4", op_count); else pass++;
    endtask

    task automatic test_backpressure;
        int lat, bad = 0; bit st, bz;
        rsp_ready = 1'b0;
        do_op(1'b0, 4'd2, 4'd3, 4'b0000, lat, st, bz);
        total++; if (lat !== 2) $display("FAIL bp_latency got %0d exp 2", lat); else pass++;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err} !== {1'b1, 1'b0, 8'h05, 1'b0, 1'b0}) bad++;
            if (req0_ready || req1_ready) bad++;
            tick;
        end
        total++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles exp 0", bad); else pass++;
        total++; if (op_count !== 16'd4) $display("FAIL bp_count_held got %0d exp 4", op_count); else pass++;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        tick;
        total++; if (rsp_valid !== 1'b0 || op_count !== 16'd5) $display("FAIL bp_release got v=%b cnt=%0d exp v=0 cnt=5", rsp_valid, op_count); else pass++;
    endtask

    task automatic test_reset_mid_exec;
        int lat, seen = 0; bit st, bz;
        req1_a = 4'd6; req1_b = 4'd3; req1_sel = 4'b0011; req1_valid = 1'b1;
        #1;
        total++; if (req1_ready !== 1'b1) $display("FAIL rst_pre_accept got %b exp 1", req1_ready); else pass++;
        tick;
        req1_valid = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        total++; if ({alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err} !== 24'h0) $display("FAIL rst_mid_outputs got %h exp 000000", {alu_a, alu_b, alu_sel, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err}); else pass++;
        total++; if (op_count !== 16'd0) $display("FAIL rst_mid_count got %0d exp 0", op_count); else pass++;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (rsp_valid) seen++;
        end
        total++; if (seen !== 0) $display("FAIL rst_no_response got %0d exp 0", seen); else pass++;
        req0_a = 4'd4; req0_b = 4'd4; req0_sel = 4'b0000; req0_valid = 1'b1;
        req1_a = 4'd1; req1_b = 4'd1; req1_sel = 4'b0000; req1_valid = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rst_first_grant got %b exp 10", {req0_ready, req1_ready}); else pass++;
        do_op(1'b0, 4'd4, 4'd4, 4'b0000, lat, st, bz);
        total++; if ({rsp_id, rsp_result} !== {1'b0, 8'h08} || lat !== 2) $display("FAIL rst_next_op got id=%b res=%h lat=%0d exp id=0 res=08 lat=2", rsp_id, rsp_result, lat); else pass++;
        tick;
        total++; if (op_count !== 16'd1) $display("FAIL rst_next_count got %0d exp 1", op_count); else pass++;
    endtask

    initial begin
        test_reset;
        test_req0_add;
        test_req1_add;
        test_div;
        test_div_zero;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_exec;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Two-requester front end for the shared 4-bit ALU datapath (ops 0000-1111, 8-bit result, carry flag).
- Arbitrates round-robin, latches one operation, and drives the ALU's A/B/select inputs from registers.
- Holds division for a configurable number of cycles, captures the result and flags, and returns a response tagged with the requester id through a valid/ready handshake.
- The ALU stays a separate combinational instance wired through the alu_* ports.

Parameters:
DIV_CYCLES, 4, cycles spent in EXEC for select 4'b0011 (division); legal range 1-15.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  4  requester 0 operand A
req0_b  in  4  requester 0 operand B
req0_sel  in  4  requester 0 ALU select
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 operation accepted this cycle
req1_a  in  4  requester 1 operand A
req1_b  in  4  requester 1 operand B
req1_sel  in  4  requester 1 ALU select
alu_a  out  4  registered operand A to ALU
alu_b  out  4  registered operand B to ALU
alu_sel  out  4  registered select to ALU
alu_out  in  8  ALU result
alu_carry  in  1  ALU carry-out
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the operation
rsp_result  out  8  captured result
rsp_carry  out  1  captured carry-out
rsp_err  out  1  division by zero
op_count  out  CNT_W  completed responses; wraps to 0

Behaviour:
- Reset (async, rst high):
  - State goes to IDLE; last_grant=1, so requester 0 wins first.
  - All outputs go to 0: alu_a/b/sel, rsp_* and op_count. Both ready signals go low.
  - An operation in flight is dropped and no response is issued.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester not equal to last_grant.
  - reqN_ready is combinational and high only for the granted requester, in IDLE only.
  - On valid & ready, latch a/b/sel into the alu_* registers and latch id.
  - On the same accept, load cnt = DIV_CYCLES if sel==4'b0011, else 1. Then go to EXEC.
  - With no valid, stay in IDLE; alu_* hold their previous values.
- EXEC:
  - alu_* stay stable.
  - If cnt > 1, decrement cnt.
  - If cnt == 1, capture rsp_result=alu_out and rsp_carry=alu_carry, then go to RESP.
  - On capture, rsp_err = (sel==4'b0011 && B==0). When rsp_err=1, rsp_result is forced to 8'h00 and rsp_carry to 0.
- RESP:
  - rsp_valid=1; rsp_id, rsp_result, rsp_carry and rsp_err are held stable until rsp_ready.
  - On the handshake: last_grant <= rsp_id, op_count increments (wrapping at 2^CNT_W), then go to IDLE.
  - rsp_valid drops in the cycle after the handshake.
- Latency, with accept in cycle T:
  - Non-divide: rsp_valid is first high in T+2.
  - Divide: rsp_valid is first high in T+1+DIV_CYCLES.
- Throughput: at most one operation in flight. Minimum spacing between accepts is 3 cycles when rsp_ready is held high.
- Both ready signals are low in EXEC and RESP. A requester dropping valid before acceptance is legal; arbitration re-evaluates every IDLE cycle.
- Width: the operation values are whatever the ALU produces. The arbiter performs no arithmetic except on cnt and op_count.

Test Plan:
- Requester 0 only: A=3, B=5, sel=0000, accept at T, rsp_ready=1 -> rsp_valid in T+2 with id=0, result=8'h08, carry=0, err=0; op_count=1 afterwards.
- Requester 1 only: A=9, B=8, sel=0000 -> result=8'h11, carry=1, id=1.
- Division: A=13, B=4, sel=0011, DIV_CYCLES=4 -> alu_* stable for 4 EXEC cycles; rsp_valid in T+5 with result=8'h03, err=0.
- Division by zero: A=7, B=0, sel=0011 -> result=8'h00, carry=0, err=1.
- Both requesters valid continuously from reset with distinct ops and rsp_ready=1 -> grants alternate 0,1,0,1. Each accept is exactly 3 cycles after the previous one, and no ready is high outside IDLE.
- Backpressure and reset:
  - rsp_ready held low for 5 cycles in RESP -> rsp_* stable and both ready signals low throughout.
  - rst asserted mid-EXEC -> all outputs 0 immediately, no response, and the next accept goes to requester 0.
